// File: rtl/fsm_pkt_gen.sv
// Packet word generator: header nibble, captured payload and a wrapping sequence count.
// Optional macro FSM_PKT_GEN_ERR_INJ_EN adds an inj_err input that zeroes the header of one word.
module fsm_pkt_gen #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            reset,
`ifdef FSM_PKT_GEN_ERR_INJ_EN
  input  logic                            inj_err,
`endif
  input  logic [BUS_SIZE-2*WORD_SIZE-1:0] data_in,
  input  logic                            valid_in,
  input  logic                            restart,
  output logic                            ready,
  output logic [BUS_SIZE-1:0]             bus_data_out,
  output logic                            valid_out,
  output logic [4:0]                      state
);

  localparam int DATA_W = BUS_SIZE - 2*WORD_SIZE;

  typedef enum logic [4:0] {
    ST_RESET     = 5'b00001,
    ST_IDLE      = 5'b00010,
    ST_FIRST_PKT = 5'b00100,
    ST_REG_PKT   = 5'b01000,
    ST_PAUSE     = 5'b10000
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [WORD_SIZE-1:0] seq_r;
  logic [WORD_SIZE-1:0] seq_next_s;
  logic [BUS_SIZE-1:0]  bus_r;
  logic [BUS_SIZE-1:0]  word_s;
  logic                 valid_r;
  logic                 ready_r;
  logic                 capture_s;
  logic                 hdr_err_s;

  function automatic logic [BUS_SIZE-1:0] build_word(
    input logic                 hdr_err,
    input logic [DATA_W-1:0]    payload,
    input logic [WORD_SIZE-1:0] seq
  );
    logic [WORD_SIZE-1:0] hdr;
    hdr = hdr_err ? {WORD_SIZE{1'b0}} : {WORD_SIZE{1'b1}};
    return {hdr, payload, seq};
  endfunction

`ifdef FSM_PKT_GEN_ERR_INJ_EN
  assign hdr_err_s = inj_err;
`else
  assign hdr_err_s = 1'b0;
`endif

  // Next-state, capture decision and next sequence value; restart beats valid_in.
  always_comb begin
    state_next_s = state_r;
    seq_next_s   = seq_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_RESET: begin
        state_next_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (restart) begin
          state_next_s = ST_IDLE;
        end else if (valid_in && ready_r) begin
          capture_s    = 1'b1;
          seq_next_s   = {WORD_SIZE{1'b0}};
          state_next_s = ST_FIRST_PKT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FIRST_PKT, ST_REG_PKT, ST_PAUSE: begin
        if (restart) begin
          state_next_s = ST_IDLE;
        end else if (valid_in && ready_r) begin
          capture_s    = 1'b1;
          seq_next_s   = seq_r + {{(WORD_SIZE-1){1'b0}}, 1'b1};
          state_next_s = ST_REG_PKT;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      default: begin
        // Corrupted (non one-hot) state code recovers through RESET.
        state_next_s = ST_RESET;
      end
    endcase
  end

  assign word_s = build_word(hdr_err_s, data_in, seq_next_s);

  // State, sequence and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_RESET;
      seq_r   <= {WORD_SIZE{1'b0}};
      bus_r   <= {BUS_SIZE{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      seq_r   <= seq_next_s;
      valid_r <= capture_s;
      ready_r <= (state_next_s != ST_RESET);
      if (capture_s) begin
        bus_r <= word_s;
      end else begin
        bus_r <= bus_r;
      end
    end
  end

  assign ready        = ready_r;
  assign bus_data_out = bus_r;
  assign valid_out    = valid_r;
  assign state        = state_r;

endmodule

// File: doc/fsm_pkt_gen.md
FSM_PKT_GEN -- requirements
Module: fsm_pkt_gen

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 16, meaning width of the generated bus word.
REQ-002 SHALL have parameter WORD_SIZE, default 4, meaning nibble width used for the header and sequence fields.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port data_in, input, BUS_SIZE-2*WORD_SIZE bits: payload for the next packet word.
REQ-006 SHALL have port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-007 SHALL have port restart, input, 1 bit: request to restart the sequence.
REQ-008 SHALL have port ready, output, 1 bit: block accepts data_in this cycle.
REQ-009 SHALL have port bus_data_out, output, BUS_SIZE bits: generated packet word.
REQ-010 SHALL have port valid_out, output, 1 bit: bus_data_out carries a new packet word this cycle.
REQ-011 SHALL have port state, output, 5 bits: one-hot current FSM state.

Function
REQ-012 SHALL build each word with bits [BUS_SIZE-1:BUS_SIZE-WORD_SIZE] set to header 4'hF, bits [BUS_SIZE-WORD_SIZE-1:WORD_SIZE] set to captured data_in, and bits [WORD_SIZE-1:0] set to the sequence count.
REQ-013 SHALL encode states one-hot: RESET=5'b00001, IDLE=5'b00010, FIRST_PKT=5'b00100, REG_PKT=5'b01000, PAUSE=5'b10000.
REQ-014 SHALL leave RESET for IDLE on the first edge with reset high.
REQ-015 SHALL drive ready=1 in every state except RESET, where ready=0.
REQ-016 SHALL capture on an edge where valid_in&&ready; the word SHALL appear on bus_data_out with valid_out=1 in the following cycle, a one-cycle latency.
REQ-017 In IDLE, a capture SHALL go to FIRST_PKT with sequence 0; no capture SHALL stay in IDLE.
REQ-018 In FIRST_PKT, REG_PKT or PAUSE, a capture SHALL go to REG_PKT with sequence = previous sequence + 1, modulo 2^WORD_SIZE (15 wraps to 0).
REQ-019 In FIRST_PKT or REG_PKT with no capture, the FSM SHALL go to PAUSE with valid_out=0 and the sequence held.
REQ-020 SHALL keep bus_data_out holding the last word whenever valid_out=0.
REQ-021 restart=1 SHALL force IDLE on the next edge and take priority over valid_in, with no word captured that edge.
REQ-022 Any state code that is not one-hot SHALL go to RESET on the next edge.

Reset
REQ-023 With reset=0 at an edge, the block SHALL set state=RESET, bus_data_out=0, valid_out=0 and sequence=0, overriding all other inputs.
REQ-024 Reset asserted mid-packet SHALL discard the in-flight word; the next packet after reset SHALL carry sequence 0 via FIRST_PKT.

Configuration
REQ-025 Macro FSM_PKT_GEN_ERR_INJ_EN defined: the block SHALL add input port inj_err, 1 bit; inj_err=1 on a capture edge SHALL replace the header nibble with 4'h0 for that word only, and the sequence SHALL still advance normally.
REQ-026 Macro FSM_PKT_GEN_ERR_INJ_EN undefined: port inj_err SHALL be absent and the header SHALL always be 4'hF.

Verification
REQ-027 Bench SHALL check: reset=0 for 2 cycles, then high -> state 00001 then 00010; bus_data_out=0, valid_out=0, ready=0 in RESET and ready=1 in IDLE.
REQ-028 Bench SHALL check: BUS_SIZE=16, data_in=8'hA5 for 3 consecutive cycles -> words 16'hFA50, 16'hFA51, 16'hFA52; states FIRST_PKT, REG_PKT, REG_PKT.
REQ-029 Bench SHALL check: 17 back-to-back captures of 8'h3C -> sequences 0..15 then 0 (16'hF3CF then 16'hF3C0).
REQ-030 Bench SHALL check: capture at seq 4, idle 3 cycles, capture 8'h11 -> state PAUSE, valid_out=0, output held at 16'hF__4, then 16'hF115.
REQ-031 Bench SHALL check: restart=1 together with valid_in=1 at seq 7 -> IDLE with no word; next capture of 8'h22 -> 16'hF220 in FIRST_PKT.
REQ-032 Bench SHALL check, with FSM_PKT_GEN_ERR_INJ_EN defined: inj_err=1 on the capture of 8'h5A at seq 2 -> 16'h05A2, and the next clean capture -> 16'hF5A3.
